// File: rtl/fft_8p_stream_ctrl.sv
// Streaming sequencer around the parallel N-point FFT core: serial frame fill, latency hold,
// result capture and natural-order serial replay over valid/ready.
module fft_8p_stream_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int N            = 8,
  parameter int CORE_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_real,
  input  logic [DATA_WIDTH-1:0]          s_imag,
  input  logic                           s_last,
  output logic [N-1:0][DATA_WIDTH-1:0]   fft_x_real,
  output logic [N-1:0][DATA_WIDTH-1:0]   fft_x_imag,
  input  logic [N-1:0][DATA_WIDTH-1:0]   fft_X_real,
  input  logic [N-1:0][DATA_WIDTH-1:0]   fft_X_imag,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_real,
  output logic [DATA_WIDTH-1:0]          m_imag,
  output logic [$clog2(N)-1:0]           m_idx,
  output logic                           m_last,
  output logic                           frame_err,
  output logic [1:0]                     fsm_state
);

  // Handshake: a beat moves on every rising edge where valid && ready; the sender holds
  // its payload stable while valid is high and ready is low.

  localparam int IW = $clog2(N);
  localparam int LW = (CORE_LATENCY > 0) ? $clog2(CORE_LATENCY + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [LW-1:0] LAT_MAX  = LW'(CORE_LATENCY);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]                    in_state;
  logic [0:0]                    out_state;
  logic [IW-1:0]                 wr_idx;
  logic [IW-1:0]                 rd_idx;
  logic [LW-1:0]                 lat_cnt;
  logic [N-1:0][DATA_WIDTH-1:0]  out_real;
  logic [N-1:0][DATA_WIDTH-1:0]  out_imag;

  logic s_xfer;
  logic m_xfer;
  logic last_beat;
  logic capture;

  // Both ready and valid are forced low while reset is asserted, before state clears.
  assign s_ready   = arst_n && (in_state == FILL);
  assign m_valid   = arst_n && (out_state == DRAIN);
  assign s_xfer    = s_valid && s_ready;
  assign m_xfer    = m_valid && m_ready;
  assign last_beat = m_xfer && (rd_idx == LAST_IDX);
  assign capture   = (in_state == HOLD) && (lat_cnt == LAT_MAX) &&
                     ((out_state == EMPTY) || last_beat);

  assign m_real    = out_real[rd_idx];
  assign m_imag    = out_imag[rd_idx];
  assign m_idx     = rd_idx;
  assign m_last    = (rd_idx == LAST_IDX);
  assign fsm_state = {in_state, out_state};

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      in_state   <= FILL;
      out_state  <= EMPTY;
      wr_idx     <= '0;
      rd_idx     <= '0;
      lat_cnt    <= '0;
      frame_err  <= 1'b0;
      fft_x_real <= '0;
      fft_x_imag <= '0;
      out_real   <= '0;
      out_imag   <= '0;
    end else begin
      frame_err <= 1'b0;

      case (in_state)
        FILL: begin
          if (s_xfer) begin
            fft_x_real[wr_idx] <= s_real;
            fft_x_imag[wr_idx] <= s_imag;
            if (wr_idx == LAST_IDX) begin
              in_state <= HOLD;
              wr_idx   <= '0;
              lat_cnt  <= '0;
            end else if (s_last) begin
              wr_idx    <= '0;
              frame_err <= 1'b1;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        default: begin
          if (lat_cnt != LAT_MAX) lat_cnt <= lat_cnt + 1'b1;
          if (capture) in_state <= FILL;
        end
      endcase

      // A capture coinciding with the final beat reloads the buffer without an EMPTY gap.
      if (capture) begin
        out_real  <= fft_X_real;
        out_imag  <= fft_X_imag;
        out_state <= DRAIN;
        rd_idx    <= '0;
      end else if (m_xfer) begin
        if (rd_idx == LAST_IDX) begin
          out_state <= EMPTY;
          rd_idx    <= '0;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_8p_stream_ctrl.sv
// Bench for fft_8p_stream_ctrl: a DFT core stub with two register stages, directed scenarios
// and randomized traffic checked against a frame-level reference model.
module tb_fft_8p_stream_ctrl;

  typedef logic [7:0][15:0] vec_t;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_real;
  logic [15:0] s_imag;
  logic        s_last;
  vec_t        fft_x_real;
  vec_t        fft_x_imag;
  vec_t        core_r = '0;
  vec_t        core_i = '0;
  vec_t        st1_r = '0;
  vec_t        st1_i = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_real;
  logic [15:0] m_imag;
  logic [2:0]  m_idx;
  logic        m_last;
  logic        frame_err;
  logic [1:0]  fsm_state;

  fft_8p_stream_ctrl #(.DATA_WIDTH(16), .N(8), .CORE_LATENCY(2)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
    .fft_x_real(fft_x_real), .fft_x_imag(fft_x_imag),
    .fft_X_real(core_r), .fft_X_imag(core_i),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_idx(m_idx), .m_last(m_last), .frame_err(frame_err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference DFT (used by the core stub and the model) ----------------
  function automatic vec_t dft(input vec_t xr, input vec_t xi, input bit imag_part);
    vec_t r;
    real  sr, si, a;
    for (int k = 0; k < 8; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 8; n++) begin
        a  = 2.0 * 3.14159265358979 * n * k / 8.0;
        sr = sr + $itor($signed(xr[n])) * $cos(a) + $itor($signed(xi[n])) * $sin(a);
        si = si + $itor($signed(xi[n])) * $cos(a) - $itor($signed(xr[n])) * $sin(a);
      end
      r[k] = imag_part ? 16'(int'(si)) : 16'(int'(sr));
    end
    return r;
  endfunction

  // Core stub: CORE_LATENCY=2 register stages from fft_x to fft_X.
  always @(posedge clk) begin
    st1_r  <= dft(fft_x_real, fft_x_imag, 1'b0);
    st1_i  <= dft(fft_x_real, fft_x_imag, 1'b1);
    core_r <= st1_r;
    core_i <= st1_i;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [35:0] exp_q[$];
  vec_t        fr, fi;
  int          fcnt    = 0;
  int          err_cyc = -1;
  int          t_last  = 0;
  int          mode    = 0;   // 1: impulse constants, 2: DC constants

  always @(negedge clk) begin
    if (!arst_n) begin
      fcnt    = 0;
      err_cyc = -1;
      exp_q.delete();
    end else begin
      check("frame_err", frame_err, (cyc == err_cyc));
      if (s_valid && s_ready) begin
        fr[fcnt] = s_real;
        fi[fcnt] = s_imag;
        if (fcnt == 7) begin
          vec_t xr, xi;
          xr = dft(fr, fi, 1'b0);
          xi = dft(fr, fi, 1'b1);
          for (int k = 0; k < 8; k++) exp_q.push_back({xr[k], xi[k], 3'(k), (k == 7)});
          fcnt   = 0;
          t_last = cyc;
        end else if (s_last) begin
          fcnt    = 0;
          err_cyc = cyc + 1;
        end else begin
          fcnt++;
        end
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_bin", 64'(exp_q.size()), 64'd1);
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          check("bin", {m_real, m_imag, m_idx, m_last}, e);
          if (mode == 1) check("impulse_bin", {m_real, m_imag}, {16'd256, 16'd0});
          if (mode == 2) check("dc_bin", {m_real, m_imag}, {(e[3:1] == 3'd0) ? 16'd256 : 16'd0, 16'd0});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  function automatic logic [15:0] rand_sample();
    int v;
    v = int'($urandom_range(0, 2000)) - 1000;
    return 16'(v);
  endfunction

  task automatic send_beat(input logic [15:0] re, input logic [15:0] im, input logic last);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_real  = re;
    s_imag  = im;
    s_last  = last;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (s_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("s_ready_timeout", 64'(done), 64'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input vec_t re, input vec_t im, input int gap_max, input int early);
    for (int i = 0; i < 8; i++) begin
      send_beat(re[i], im[i], (i == 7) || (i == early));
      if (i == early) return;
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && (exp_q.size() != 0 || m_valid); i++) @(negedge clk);
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 8; i++) v[i] = rand_sample();
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vec_t re, im;
    bit   found;
    arst_n  = 1'b0;
    s_valid = 1'b0;
    s_real  = '0;
    s_imag  = '0;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_outputs", {m_idx, m_last, frame_err, m_real, m_imag}, '0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk);
    check("fsm_after_reset", fsm_state, 2'b00);
    check("s_ready_after_reset", s_ready, 1'b1);
    @(posedge clk);
    #1;

    // Impulse: latency T+4 from the final accepted sample.
    mode = 1;
    re = '0; im = '0; re[0] = 16'd256;
    send_frame(re, im, 0, -1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_valid) found = 1'b1;
    end
    check("impulse_latency", 64'(cyc - t_last), 64'd4);
    wait_idle();
    mode = 0;

    // DC: s_ready low for T+1..T+3, high again at T+4.
    mode = 2;
    for (int i = 0; i < 8; i++) begin re[i] = 16'd32; im[i] = 16'd0; end
    send_frame(re, im, 0, -1);
    for (int d = 1; d <= 4; d++) begin
      @(negedge clk);
      check($sformatf("dc_s_ready_T+%0d", d), s_ready, (d == 4));
    end
    wait_idle();
    mode = 0;

    // Back-pressure: two frames held while the sink is stalled.
    rdy_mode = 2;
    send_frame(rand_vec(), rand_vec(), 1, -1);
    send_frame(rand_vec(), rand_vec(), 1, -1);
    repeat (20) begin
      @(negedge clk);
      check("bp_hold", {s_ready, m_valid, m_idx}, {1'b0, 1'b1, 3'd0});
    end
    check("bp_queued_bins", 64'(exp_q.size()), 64'd16);
    rdy_mode = 0;
    wait_idle();

    // Early s_last at index 3: one frame_err pulse, nothing emitted, next frame intact.
    send_frame(rand_vec(), rand_vec(), 0, 3);
    @(negedge clk);
    check("early_last_err", frame_err, 1'b1);
    @(negedge clk);
    check("early_last_err_clear", frame_err, 1'b0);
    check("early_last_no_bins", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    send_frame(rand_vec(), rand_vec(), 1, -1);
    wait_idle();

    // Reset while presenting output index 4.
    send_frame(rand_vec(), rand_vec(), 0, -1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_valid && m_idx == 3'd4) begin
        arst_n = 1'b0;
        found  = 1'b1;
      end
    end
    check("reached_out_idx4", found, 1'b1);
    @(negedge clk);
    check("rst_mid_drain_m_valid", m_valid, 1'b0);
    check("rst_mid_drain_s_ready", s_ready, 1'b0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("no_output_after_reset", m_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Reset after five input samples.
    for (int i = 0; i < 5; i++) send_beat(rand_sample(), rand_sample(), 1'b0);
    arst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_fill_s_ready", s_ready, 1'b0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    send_frame(rand_vec(), rand_vec(), 0, -1);
    wait_idle();

    // Random traffic.
    rdy_mode = 1;
    for (int f = 0; f < 50; f++) send_frame(rand_vec(), rand_vec(), 2, -1);
    rdy_mode = 0;
    wait_idle();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
